// File: rtl/nachi_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// The WAIT state exists only when DMEM_WAIT_EN is defined.
package nachi_mem_pkg;

    localparam int WORD_W = 32;
    localparam int OFS_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef DMEM_WAIT_EN
        ST_WAIT = 2'd1,
`endif
        ST_RESP = 2'd2
    } state_t;

    // Misaligned byte offset, or word index beyond the stored depth (checked before truncation).
    function automatic logic addr_fault(input logic [WORD_W-1:0] a, input int unsigned depth);
        logic [WORD_W-1:0] word_idx;
        word_idx = {{OFS_W{1'b0}}, a[WORD_W-1:OFS_W]};
        return (a[OFS_W-1:0] != {OFS_W{1'b0}}) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word storage for dmem_responder: one write port, one registered read port.
// Contents are intentionally not reset.
module dmem_ram
    import nachi_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Storage write and synchronous read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fault checking.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module dmem_responder
    import nachi_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_r, state_s;
    logic              accept_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [WORD_W-1:0] ram_rdata_s;
    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] wdata_r;
    logic              we_r;
    logic              fault_r;
`ifdef DMEM_WAIT_EN
    logic [3:0]        cnt_r, cnt_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && req;
    // The read is issued at acceptance; nothing can write memory while the access is outstanding.
    assign ram_re_s = accept_s && !we && !addr_fault(addr, DEPTH);
    assign ram_we_s = (state_r == ST_RESP) && we_r && !fault_r && !reset;

    dmem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (idx_r),
        .wdata (wdata_r),
        .re    (ram_re_s),
        .raddr (addr[OFS_W+IDX_W-1:OFS_W]),
        .rdata (ram_rdata_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
`ifdef DMEM_WAIT_EN
        cnt_s   = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req) begin
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_s = ST_RESP;
                    end
`else
                    state_s = ST_RESP;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef DMEM_WAIT_EN
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
`endif
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request capture and registered outputs; ready/err/rdata update at the edge ending RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rdata   <= {WORD_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            we_r    <= 1'b0;
            fault_r <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_r   <= 4'd0;
`endif
        end else begin
            state_r <= state_s;
`ifdef DMEM_WAIT_EN
            cnt_r   <= cnt_s;
`endif
            ready   <= (state_r == ST_RESP);
            err     <= (state_r == ST_RESP) && fault_r;
            busy    <= (state_r != ST_IDLE) || req;
            if (accept_s) begin
                idx_r   <= addr[OFS_W+IDX_W-1:OFS_W];
                wdata_r <= wdata;
                we_r    <= we;
                fault_r <= addr_fault(addr, DEPTH);
            end
            if (state_r == ST_RESP) begin
                if (fault_r) begin
                    rdata <= {WORD_W{1'b0}};
                end else if (!we_r) begin
                    rdata <= ram_rdata_s;
                end
            end
        end
    end

endmodule
